remap_pwl_pipe: RTL and testbench

// - Pipelined, parametrised piecewise-linear remapper: maps input code m1 to output code m2 via per-piece

---
 rtl/remap_pkg.sv | 20 ++
 rtl/remap_piece_find.sv | 38 +++
 rtl/remap_pwl_pipe.sv | 190 +++++++++++++++++++
 tb/tb_remap_pwl_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remap_pkg.sv
// Shared constants for the piecewise-linear remap pipeline:
// slope codes, cfg table selects, internal sum headroom.
package remap_pkg;

  localparam logic [2:0] SLOPE_SHL2     = 3'd0;
  localparam logic [2:0] SLOPE_ZERO     = 3'd1;
  localparam logic [2:0] SLOPE_NEG_SHR3 = 3'd2;
  localparam logic [2:0] SLOPE_NEG_SHR2 = 3'd3;
  localparam logic [2:0] SLOPE_SHR1     = 3'd4;
  localparam logic [2:0] SLOPE_NEG_SHR1 = 3'd5;

  localparam logic [1:0] CFG_NODE   = 2'd0;
  localparam logic [1:0] CFG_INTCPT = 2'd1;
  localparam logic [1:0] CFG_SLOPE  = 2'd2;
  localparam logic [1:0] CFG_RSVD   = 2'd3;

  // extra bits over M1_W so m1 + (m1<<2) + intercept + 1 never wraps
  localparam int SUM_XW = 4;

endpackage

// File: rtl/remap_piece_find.sv
// Node compare and priority encoder: picks the piece holding m1
// and flags codes outside (node[0], node[PIECE_NUM]].
module remap_piece_find
  import remap_pkg::*;
#(
  parameter int M1_W      = 16,
  parameter int PIECE_NUM = 42,
  parameter int IDX_W     = 6
) (
  input  logic [M1_W-1:0]  m1,
  input  logic [M1_W-1:0]  node [PIECE_NUM+1],
  output logic [IDX_W-1:0] piece,
  output logic             oor
);

  logic             lo;
  logic             hi;
  logic [IDX_W-1:0] hit_idx;

  // scan high to low so the lowest matching interval wins
  always_comb begin
    lo      = (m1 <= node[0]);
    hi      = (m1 > node[PIECE_NUM]);
    hit_idx = IDX_W'(PIECE_NUM - 1);
    for (int i = PIECE_NUM - 1; i >= 0; i--) begin
      if ((node[i] < m1) && (m1 <= node[i+1]))
        hit_idx = IDX_W'(i);
    end
    oor = lo | hi;
    if (lo)
      piece = '0;
    else if (hi)
      piece = IDX_W'(PIECE_NUM - 1);
    else
      piece = hit_idx;
  end

endmodule

// File: rtl/remap_pwl_pipe.sv
// 3-stage piecewise-linear m1->m2 remap with cfg-writable tables.
// Define REMAP_ROUND_EN to round half up instead of truncating.
// Table contents are undefined at power-up; load them over cfg.
module remap_pwl_pipe
  import remap_pkg::*;
#(
  parameter int M1_W      = 16,
  parameter int M2_W      = 15,
  parameter int PIECE_NUM = 42,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M1_W-1:0]  m1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M2_W-1:0]  m2,
  output logic             out_oor,
  output logic             out_sat,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [IDX_W:0]   cfg_addr,
  input  logic [M1_W-1:0]  cfg_wdata
);

  localparam int SUM_W = M1_W + SUM_XW;

  localparam logic [IDX_W:0] NODE_LAST =
    (IDX_W+1)'(PIECE_NUM);
  localparam logic signed [SUM_W-1:0] M2_MAX =
    SUM_W'((1 << M2_W) - 1);

  typedef struct packed {
    logic [M1_W-1:0] m1;
    logic [M1_W-1:0] intcpt;
    logic [2:0]      slope;
    logic            oor;
  } s1_t;

  typedef struct packed {
    logic [M1_W-1:0]         m1;
    logic signed [SUM_W-1:0] term;
    logic [M1_W-1:0]         intcpt;
    logic                    oor;
  } s2_t;

  logic [M1_W-1:0] node_tab   [PIECE_NUM+1];
  logic [M1_W-1:0] intcpt_tab [PIECE_NUM];
  logic [2:0]      slope_tab  [PIECE_NUM];

  logic node_we;
  logic intcpt_we;
  logic slope_we;

  logic [IDX_W-1:0] piece;
  logic             piece_oor;

  logic adv;
  logic s1_valid;
  logic s2_valid;
  s1_t  s1;
  s2_t  s2;

  logic signed [SUM_W-1:0] ext_m1;
  logic signed [SUM_W-1:0] term;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] half;
  logic [M2_W-1:0]         m2_nx;
  logic                    sat_nx;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign node_we   = cfg_we && (cfg_sel == CFG_NODE)
                  && (cfg_addr <= NODE_LAST);
  assign intcpt_we = cfg_we && (cfg_sel == CFG_INTCPT)
                  && (cfg_addr < NODE_LAST);
  assign slope_we  = cfg_we && (cfg_sel == CFG_SLOPE)
                  && (cfg_addr < NODE_LAST);

  // table writes; reads happen only in S1, so a write lands for the
  // sample accepted on the following cycle
  always_ff @(posedge clk) begin
    unique case (1'b1)
      node_we:
        node_tab[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
      intcpt_we:
        intcpt_tab[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
      slope_we:
        slope_tab[cfg_addr[IDX_W-1:0]] <= cfg_wdata[2:0];
      default: ;
    endcase
  end

  remap_piece_find #(
    .M1_W      (M1_W),
    .PIECE_NUM (PIECE_NUM),
    .IDX_W     (IDX_W)
  ) u_find (
    .m1    (m1),
    .node  (node_tab),
    .piece (piece),
    .oor   (piece_oor)
  );

  // S1: capture m1 with its piece's intercept and slope code
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.m1     <= m1;
        s1.intcpt <= intcpt_tab[piece];
        s1.slope  <= slope_tab[piece];
        s1.oor    <= piece_oor;
      end
    end
  end

  // shift-add slope term from the slope code
  always_comb begin
    ext_m1 = SUM_W'(s1.m1);
    term   = '0;
    unique case (s1.slope)
      SLOPE_SHL2:     term = ext_m1 <<< 2;
      SLOPE_NEG_SHR3: term = -(ext_m1 >>> 3);
      SLOPE_NEG_SHR2: term = -(ext_m1 >>> 2);
      SLOPE_SHR1:     term = ext_m1 >>> 1;
      SLOPE_NEG_SHR1: term = -(ext_m1 >>> 1);
      default:        term = '0;
    endcase
  end

  // S2: hold slope term alongside m1 and intercept
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2.m1     <= s1.m1;
        s2.term   <= term;
        s2.intcpt <= s1.intcpt;
        s2.oor    <= s1.oor;
      end
    end
  end

  // full-width sum, halve, clamp into the M2_W range
  always_comb begin
    sum = SUM_W'(s2.m1) + s2.term
        + SUM_W'(signed'(s2.intcpt));
`ifdef REMAP_ROUND_EN
    sum = sum + SUM_W'(1);
`endif
    half   = sum >>> 1;
    m2_nx  = half[M2_W-1:0];
    sat_nx = 1'b0;
    if (sum < 0) begin
      m2_nx  = '0;
      sat_nx = 1'b1;
    end else if (half > M2_MAX) begin
      m2_nx  = '1;
      sat_nx = 1'b1;
    end
  end

  // S3: registered outputs, frozen while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      m2        <= '0;
      out_oor   <= 1'b0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        m2      <= m2_nx;
        out_oor <= s2.oor;
        out_sat <= sat_nx;
      end
    end
  end

endmodule

// File: tb/tb_remap_pwl_pipe.sv
// Scoreboard bench for remap_pwl_pipe: directed vectors,
// expected results queued at issue and popped by a monitor.
module tb_remap_pwl_pipe;

`ifdef REMAP_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct packed {
    logic [14:0] m2;
    logic        oor;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] m1;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] m2;
  logic        out_oor;
  logic        out_sat;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  int   checks = 0;
  int   fails  = 0;
  exp_t q[$];

  logic held = 1'b0;
  exp_t held_v;

  remap_pwl_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m1        (m1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m2        (m2),
    .out_oor   (out_oor),
    .out_sat   (out_sat),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  always #5 clk = ~clk;

  // sum is hand-computed and known not to saturate
  function automatic exp_t ex(input int sum, input bit oor);
    exp_t e;
    e.m2  = 15'((sum + RND) >>> 1);
    e.oor = oor;
    e.sat = 1'b0;
    return e;
  endfunction

  function automatic exp_t ex_sat(input logic [14:0] v,
                                  input bit oor);
    exp_t e;
    e.m2  = v;
    e.oor = oor;
    e.sat = 1'b1;
    return e;
  endfunction

  task automatic check(input string nm, input int act,
                       input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // monitor: pop on each handshake, verify hold while stalled
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (held) begin
        checks++;
        if ({m2, out_oor, out_sat} !== held_v) begin
          fails++;
          $display("FAIL hold: got %h/%b/%b want %h/%b/%b",
                   m2, out_oor, out_sat,
                   held_v.m2, held_v.oor, held_v.sat);
        end
      end
      if (out_ready) begin
        held = 1'b0;
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected: got m2=%0d want none", m2);
        end else begin
          e = q.pop_front();
          if ({m2, out_oor, out_sat} !== e) begin
            fails++;
            $display("FAIL out: got %0d/%b/%b want %0d/%b/%b",
                     m2, out_oor, out_sat, e.m2, e.oor, e.sat);
          end
        end
      end else begin
        held   = 1'b1;
        held_v = {m2, out_oor, out_sat};
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic wr(input logic [1:0] sel, input int addr,
                    input int data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = 7'(addr);
    cfg_wdata = 16'(data);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input int v, input exp_t e);
    int n;
    m1       = 16'(v);
    in_valid = 1'b1;
    q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      n++;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    m1        = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_m2", int'(m2), 0);
    check("rst_oor", int'(out_oor), 0);
    check("rst_sat", int'(out_sat), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i <= 42; i++) wr(2'd0, i, i * 100);
    for (int i = 0; i < 42; i++) wr(2'd1, i, 0);
    for (int i = 0; i < 42; i++) wr(2'd2, i, 1);

    send(250, ex(250, 0));
    @(negedge clk);
    check("lat_c1", int'(out_valid), 0);
    @(negedge clk);
    check("lat_c2", int'(out_valid), 0);
    @(negedge clk);
    check("lat_c3", int'(out_valid), 1);
    drain();

    send(0, ex(0, 1));
    send(5000, ex(5000, 1));
    send(4100, ex(4100, 0));
    drain();

    wr(2'd2, 2, 3);
    wr(2'd1, 2, 40);
    send(240, ex(220, 0));
    send(241, ex(221, 0));
    drain();

    wr(2'd1, 0, -10);
    send(0, ex_sat(15'd0, 1));
    send(50, ex(40, 0));
    send(100, ex(90, 0));
    send(101, ex(101, 0));
    drain();

    wr(2'd2, 41, 0);
    wr(2'd1, 41, 16'h7FFF);
    send(4200, ex(53767, 0));
    send(20000, ex_sat(15'h7FFF, 1));
    send(65535, ex_sat(15'h7FFF, 1));
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++)
          send(1000 + 101 * i, ex(1000 + 101 * i, 0));
      end
      begin
        for (int k = 0; k < 45; k++) begin
          out_ready = (k % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    wr(2'd1, 2, 0);
    cfg_we    = 1'b1;
    cfg_sel   = 2'd1;
    cfg_addr  = 7'd2;
    cfg_wdata = 16'd100;
    send(250, ex(188, 0));
    cfg_we = 1'b0;
    send(250, ex(288, 0));
    drain();

    out_ready = 1'b0;
    send(1000, ex(1000, 0));
    send(1100, ex(1100, 0));
    send(1200, ex(1200, 0));
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_stale", cnt, 0);
    @(posedge clk);
    #1;
    send(250, ex(288, 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
